// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding
// imem requests and buffers returned words in a queue toward decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_valid_q, req_valid_d;
    logic          pend_drop_q, pend_drop_d;
    logic          discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   ent_pc_q [QDEPTH];
    logic [31:0]   ent_pc_d [QDEPTH];
    logic [31:0]   ent_instr_q [QDEPTH];
    logic [31:0]   ent_instr_d [QDEPTH];

    logic hs, push, pop, has_slot, discard_rst;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_valid_d = req_valid_q;
        pend_drop_d = pend_drop_q;
        discard_d   = discard_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        hs          = req_valid_q & imem_req_ready;
        has_slot    = count_q < CW'(QDEPTH);
        pop         = id_valid & id_ready;
        push        = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (req_valid_q) begin
                    if (hs) begin
                        req_valid_d = 1'b0;
                        pend_drop_d = 1'b0;
                        state_d = (redirect_valid || pend_drop_q)
                                  ? S_DROP : S_WAIT;
                    end else if (redirect_valid) begin
                        pend_drop_d = 1'b1;
                    end
                end else begin
                    // a pre-reset response is still owed; swallow it first
                    if (discard_q && imem_rsp_valid) begin
                        discard_d = 1'b0;
                    end
                    if (!redirect_valid && !stall && !discard_q
                        && has_slot) begin
                        req_valid_d = 1'b1;
                        addr_d      = pc_q;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    if (!redirect_valid) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                ent_pc_d[tail_q]    = pc_q;
                ent_instr_d[tail_q] = imem_rsp_data;
                tail_d              = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        discard_rst = (state_q != S_REQ) || hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_valid_q <= 1'b0;
            pend_drop_q <= 1'b0;
            discard_q   <= discard_rst && !imem_rsp_valid;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_valid_q <= req_valid_d;
            pend_drop_q <= pend_drop_d;
            discard_q   <= discard_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_pc_q    <= ent_pc_d;
        ent_instr_q <= ent_instr_d;
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_valid_q ? addr_q : pc_q;
    assign id_valid       = count_q != '0;
    assign id_instr       = id_valid ? ent_instr_q[head_q] : 32'd0;
    assign id_pc          = id_valid ? ent_pc_q[head_q] : 32'd0;
    assign id_pc_plus4    = id_valid ? ent_pc_q[head_q] + 32'd4 : 32'd0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory responder plus a program-order
// reference model that knows only the PC sequence and redirect targets.
module tb_if_fetch_stage;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    if_fetch_stage #(.RESET_PC(RPC), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int          mem_rdy_mode = 0;
    int          id_rdy_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          stall_v = 0;
    bit          redir_now = 0;
    bit          redir_on_rsp = 0;
    bit          rst_now = 0;
    logic [31:0] redir_tgt = '0;

    bit          m_busy = 0;
    int          m_left = 0;
    logic [31:0] m_addr = '0;

    logic [31:0] exp_pc = RPC;
    int          hs_cnt = 0;
    int          consumed = 0;
    logic [31:0] hs_q [$];
    bit          prev_pend = 0;
    logic [31:0] prev_addr = '0;
    bit          expect_empty = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic drive();
        bit do_redir;
        bit do_rst;
        if (expect_empty) begin
            checks++;
            if (id_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_empty id_valid=%b want 0", id_valid);
            end
        end
        if (prev_pend) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                failures++;
                $display("FAIL req_hold valid=%b addr=%h want 1 %h",
                         imem_req_valid, imem_req_addr, prev_addr);
            end
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (m_busy) begin
            if (m_left == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(m_addr);
                m_busy = 0;
            end else begin
                m_left--;
            end
        end
        do_rst = rst_now;
        rst_now = 0;
        do_redir = redir_now || (redir_on_rsp && imem_rsp_valid);
        if (redir_on_rsp && imem_rsp_valid) redir_on_rsp = 0;
        redir_now = 0;
        rst            = do_rst;
        redirect_valid = do_redir;
        redirect_pc    = do_redir ? redir_tgt : $urandom;
        stall          = stall_v;
        imem_req_ready = pick(mem_rdy_mode);
        id_ready       = pick(id_rdy_mode);

        if (id_valid && id_ready && !do_redir && !do_rst) begin
            checks++;
            if (id_pc !== exp_pc) begin
                failures++;
                $display("FAIL id_pc got=%h want=%h", id_pc, exp_pc);
            end
            checks++;
            if (id_instr !== instr_of(exp_pc)) begin
                failures++;
                $display("FAIL id_instr got=%h want=%h pc=%h",
                         id_instr, instr_of(exp_pc), exp_pc);
            end
            checks++;
            if (id_pc_plus4 !== exp_pc + 32'd4) begin
                failures++;
                $display("FAIL id_pc_plus4 got=%h want=%h",
                         id_pc_plus4, exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end

        if (imem_req_valid && imem_req_ready) begin
            checks++;
            if (m_busy) begin
                failures++;
                $display("FAIL single_outstanding got=2 want=1 addr=%h",
                         imem_req_addr);
            end
            m_busy = 1;
            m_addr = imem_req_addr;
            m_left = $urandom_range(lat_max, lat_min) - 1;
            hs_cnt++;
            hs_q.push_back(imem_req_addr);
        end
        prev_pend    = imem_req_valid && !imem_req_ready && !do_rst;
        prev_addr    = imem_req_addr;
        expect_empty = do_redir || do_rst;
        if (do_redir) exp_pc = redir_tgt;
        if (do_rst) exp_pc = RPC;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
    endtask

    task automatic timeout(input string name);
        failures++;
        $display("FAIL %s timeout got=expired want=event", name);
    endtask

    task automatic test_reset();
        mem_rdy_mode = 0;
        id_rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            rst_now = 1;
            step();
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0
            || id_instr !== 32'd0 || id_pc !== 32'd0
            || id_pc_plus4 !== 32'd0) begin
            failures++;
            $display("FAIL reset_outs got=%b%b %h %h %h want 00 0 0 0",
                     imem_req_valid, id_valid, id_instr, id_pc, id_pc_plus4);
        end
        checks++;
        if (imem_req_addr !== RPC) begin
            failures++;
            $display("FAIL reset_addr got=%h want=%h", imem_req_addr, RPC);
        end
        drive();
    endtask

    task automatic test_seq();
        int c0;
        lat_min = 1;
        lat_max = 1;
        hs_q.delete();
        c0 = consumed;
        for (int i = 0; i < 40 && (hs_q.size() < 3 || consumed - c0 < 3); i++)
            step();
        checks++;
        if (hs_q.size() < 3) begin
            timeout("seq_requests");
        end else if (hs_q[0] !== RPC || hs_q[1] !== RPC + 32'd4
                     || hs_q[2] !== RPC + 32'd8) begin
            failures++;
            $display("FAIL seq_addrs got=%h %h %h want=%h +4 +8",
                     hs_q[0], hs_q[1], hs_q[2], RPC);
        end
    endtask

    task automatic test_backpressure();
        int h;
        int c;
        stall_v = 1;
        id_rdy_mode = 0;
        for (int i = 0; i < 8; i++) step();
        stall_v = 0;
        id_rdy_mode = 2;
        h = hs_cnt;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (hs_cnt - h != 2) begin
            failures++;
            $display("FAIL full_issue got=%0d want=2", hs_cnt - h);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_state req=%b idv=%b want 0 1",
                     imem_req_valid, id_valid);
        end
        id_rdy_mode = 0;
        c = consumed;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (consumed - c != 2) begin
            failures++;
            $display("FAIL drain_count got=%0d want=2", consumed - c);
        end
    endtask

    task automatic test_redirect_wait();
        int c;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20 && !m_busy; i++) step();
        if (!m_busy) timeout("redir_wait_hs");
        hs_q.delete();
        redir_tgt = 32'h8000_0100;
        redir_now = 1;
        step();
        c = consumed;
        for (int i = 0; i < 40 && consumed == c; i++) step();
        checks++;
        if (hs_q.size() == 0) begin
            timeout("redir_wait_fetch");
        end else if (hs_q[0] !== 32'h8000_0100) begin
            failures++;
            $display("FAIL redir_wait_addr got=%h want=80000100", hs_q[0]);
        end
    endtask

    task automatic test_redirect_rsp();
        lat_min = 1;
        lat_max = 1;
        redir_tgt = 32'h8000_0200;
        redir_on_rsp = 1;
        for (int i = 0; i < 30 && redir_on_rsp; i++) step();
        if (redir_on_rsp) begin
            redir_on_rsp = 0;
            timeout("redir_rsp");
        end
        hs_q.delete();
        for (int i = 0; i < 20 && hs_q.size() == 0; i++) step();
        checks++;
        if (hs_q.size() == 0) begin
            timeout("redir_rsp_fetch");
        end else if (hs_q[0] !== 32'h8000_0200) begin
            failures++;
            $display("FAIL redir_rsp_addr got=%h want=80000200", hs_q[0]);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_stall_hold();
        logic [31:0] a;
        int h;
        mem_rdy_mode = 2;
        for (int i = 0; i < 20 && !imem_req_valid; i++) step();
        if (!imem_req_valid) timeout("stall_issue");
        stall_v = 1;
        a = imem_req_addr;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
            failures++;
            $display("FAIL stall_hold got=%b %h want=1 %h",
                     imem_req_valid, imem_req_addr, a);
        end
        mem_rdy_mode = 0;
        h = hs_cnt;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (hs_cnt - h != 1 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_block got=%0d req=%b want=1 0",
                     hs_cnt - h, imem_req_valid);
        end
        stall_v = 0;
        for (int i = 0; i < 10 && hs_cnt < h + 2; i++) step();
        checks++;
        if (hs_cnt < h + 2) timeout("stall_resume");
    endtask

    task automatic test_wrap();
        int c;
        redir_tgt = 32'hFFFF_FFF8;
        redir_now = 1;
        step();
        c = consumed;
        for (int i = 0; i < 40 && consumed - c < 4; i++) step();
        checks++;
        if (consumed - c < 4) timeout("wrap");
    endtask

    task automatic test_reset_wait();
        int c;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20 && !m_busy; i++) step();
        if (!m_busy) timeout("rst_wait_hs");
        step();
        rst_now = 1;
        step();
        step();
        checks++;
        if (imem_req_addr !== RPC || id_valid !== 1'b0
            || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait got=%h idv=%b req=%b want=%h 0 0",
                     imem_req_addr, id_valid, imem_req_valid, RPC);
        end
        c = consumed;
        for (int i = 0; i < 40 && consumed == c; i++) step();
        checks++;
        if (consumed == c) timeout("rst_wait_fetch");
    endtask

    task automatic test_random();
        int c;
        lat_min = 1;
        lat_max = 3;
        mem_rdy_mode = 1;
        id_rdy_mode = 1;
        c = consumed;
        for (int i = 0; i < 1500; i++) begin
            stall_v = ($urandom_range(3, 0) == 0);
            if ($urandom_range(39, 0) == 0) begin
                redir_now = 1;
                case ($urandom_range(2, 0))
                    0: redir_tgt = RPC + ($urandom_range(255, 0) << 2);
                    1: redir_tgt = 32'hFFFF_FFF0;
                    default: redir_tgt = $urandom & 32'hFFFF_FFFC;
                endcase
            end
            step();
        end
        stall_v = 0;
        mem_rdy_mode = 0;
        id_rdy_mode = 0;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (consumed - c < 50) begin
            failures++;
            $display("FAIL random_progress got=%0d want>=50", consumed - c);
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        id_ready = 1'b0;
        test_reset();
        test_seq();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_stall_hold();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
